// File: rtl/ctr_stream_decryptor.sv
// AES-256 CTR-mode stream decryptor: an iterative forward cipher turns the local counter block
// into keystream, which is XORed onto each accepted ciphertext block.
module ctr_stream_decryptor #(
    parameter int unsigned NUM_BLOCKS = 8,
    parameter int unsigned CTR_WIDTH  = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic [255:0] key_i,
    input  logic [127:0] iv_i,
    input  logic         ct_valid_i,
    output logic         ct_ready_o,
    input  logic [127:0] ct_data_i,
    output logic         pt_valid_o,
    input  logic         pt_ready_i,
    output logic [127:0] pt_data_o,
    output logic         pt_last_o,
    output logic         busy_o,
    output logic         done_o,
    output logic         ctr_wrap_o
);

    typedef enum logic [2:0] {StIdle, StGen, StWaitCt, StOut, StDone} state_e;

    localparam logic [15:0]  LastIdx = 16'(NUM_BLOCKS - 1);
    localparam logic [127:0] LoMask  = (CTR_WIDTH >= 128) ? {128{1'b1}} :
                                       ((128'd1 << CTR_WIDTH) - 128'd1);
    localparam logic [3:0]   LastRound = 4'd14;

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SboxTable = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SboxTable[~{x, 3'b000} -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // AES-256 schedule step: even round-key indices use RotWord+Rcon, odd ones SubWord only.
    function automatic logic [127:0] next_round_key(input logic [127:0] prev,
                                                    input logic [31:0]  last_w,
                                                    input logic         rot_step,
                                                    input logic [7:0]   rcon);
        logic [31:0] t, w0, w1, w2, w3;
        t  = rot_step ? (sub_word({last_w[23:0], last_w[31:24]}) ^ {rcon, 24'h000000})
                      : sub_word(last_w);
        w0 = prev[127:96] ^ t;
        w1 = prev[95:64] ^ w0;
        w2 = prev[63:32] ^ w1;
        w3 = prev[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                               input logic last);
        logic [7:0]   sb [16];
        logic [7:0]   sr [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) begin
            sb[i] = sbox(s[127-8*i -: 8]);
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[4*c+r] = sb[4*((c+r)%4)+r];
            end
        end
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = sr[4*c];
            a1 = sr[4*c+1];
            a2 = sr[4*c+2];
            a3 = sr[4*c+3];
            if (last) begin
                o[127-32*c -: 32] = {a0, a1, a2, a3};
            end else begin
                o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                     a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                     a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                     xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
            end
        end
        return o ^ rk;
    endfunction

    state_e       state_q, state_d;
    logic [255:0] key_q, key_d;
    logic [127:0] ctr_q, ctr_d;
    logic [127:0] ks_q, ks_d;
    logic [15:0]  cnt_q, cnt_d;
    logic [127:0] pt_data_q, pt_data_d;
    logic         pt_valid_q, pt_valid_d;
    logic         pt_last_q, pt_last_d;
    logic         wrap_q, wrap_d;

    logic [127:0] aes_q, aes_d;
    logic [255:0] kw_q, kw_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [7:0]   rcon_q, rcon_d;
    logic         run_q, run_d;
    logic         core_done_q, core_done_d;

    logic         core_en;
    logic [127:0] ctr_inc;

    assign core_en = (state_q == StGen);
    assign ctr_inc = ctr_q + 128'd1;

    // Iterative cipher: one load cycle, fourteen round cycles, then a one-cycle done flag.
    always_comb begin
        aes_d       = aes_q;
        kw_d        = kw_q;
        rnd_d       = rnd_q;
        rcon_d      = rcon_q;
        run_d       = run_q;
        core_done_d = 1'b0;
        if (!core_en) begin
            run_d = 1'b0;
        end else if (run_q) begin
            aes_d  = aes_round(aes_q, kw_q[127:0], rnd_q == LastRound);
            kw_d   = {kw_q[127:0], next_round_key(kw_q[255:128], kw_q[31:0], rnd_q[0], rcon_q)};
            rcon_d = rnd_q[0] ? xtime(rcon_q) : rcon_q;
            if (rnd_q == LastRound) begin
                run_d       = 1'b0;
                core_done_d = 1'b1;
            end else begin
                rnd_d = rnd_q + 4'd1;
            end
        end else if (!core_done_q) begin
            aes_d  = ctr_q ^ key_q[255:128];
            kw_d   = key_q;
            rnd_d  = 4'd1;
            rcon_d = 8'h01;
            run_d  = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        ctr_d      = ctr_q;
        ks_d       = ks_q;
        cnt_d      = cnt_q;
        pt_data_d  = pt_data_q;
        pt_valid_d = pt_valid_q;
        pt_last_d  = pt_last_q;
        wrap_d     = wrap_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    key_d   = key_i;
                    ctr_d   = iv_i;
                    cnt_d   = '0;
                    wrap_d  = 1'b0;
                    state_d = StGen;
                end
            end
            StGen: begin
                if (core_done_q) begin
                    ks_d  = aes_q;
                    // Only the low field counts; the upper IV bits never see a carry.
                    ctr_d = (ctr_inc & LoMask) | (ctr_q & ~LoMask);
                    if ((ctr_q & LoMask) == LoMask) begin
                        wrap_d = 1'b1;
                    end
                    state_d = StWaitCt;
                end
            end
            StWaitCt: begin
                if (ct_valid_i) begin
                    pt_data_d  = ct_data_i ^ ks_q;
                    pt_valid_d = 1'b1;
                    pt_last_d  = (cnt_q == LastIdx);
                    state_d    = StOut;
                end
            end
            StOut: begin
                if (pt_ready_i) begin
                    pt_valid_d = 1'b0;
                    pt_last_d  = 1'b0;
                    cnt_d      = cnt_q + 16'd1;
                    state_d    = pt_last_q ? StDone : StGen;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            key_q       <= '0;
            ctr_q       <= '0;
            ks_q        <= '0;
            cnt_q       <= '0;
            pt_data_q   <= '0;
            pt_valid_q  <= 1'b0;
            pt_last_q   <= 1'b0;
            wrap_q      <= 1'b0;
            aes_q       <= '0;
            kw_q        <= '0;
            rnd_q       <= '0;
            rcon_q      <= '0;
            run_q       <= 1'b0;
            core_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            ctr_q       <= ctr_d;
            ks_q        <= ks_d;
            cnt_q       <= cnt_d;
            pt_data_q   <= pt_data_d;
            pt_valid_q  <= pt_valid_d;
            pt_last_q   <= pt_last_d;
            wrap_q      <= wrap_d;
            aes_q       <= aes_d;
            kw_q        <= kw_d;
            rnd_q       <= rnd_d;
            rcon_q      <= rcon_d;
            run_q       <= run_d;
            core_done_q <= core_done_d;
        end
    end

    assign ct_ready_o = (state_q == StWaitCt);
    assign pt_valid_o = pt_valid_q;
    assign pt_data_o  = pt_data_q;
    assign pt_last_o  = pt_last_q;
    assign busy_o     = (state_q != StIdle);
    assign done_o     = (state_q == StDone);
    assign ctr_wrap_o = wrap_q;

endmodule
